// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types, widths and lane helpers for the byte-serial RAM controller.
package mem_ctrl_pkg;
   localparam int RAM_ADDR_W = 17;
   localparam int LANE_W     = 8;
   localparam logic [31:0] ZERO_WORD = 32'h0;
   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
   function automatic logic [1:0] lo_lane(input logic [3:0] m);
      return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
   endfunction
   function automatic logic [1:0] hi_lane(input logic [3:0] m);
      return m[3] ? 2'd3 : m[2] ? 2'd2 : m[1] ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_arb: fixed-priority grant, the MEM stage wins over instruction fetch.
module mem_arb (
   input  logic if_req,
   input  logic mem_req,
   output logic grant_mem,
   output logic grant_if
);
   assign grant_mem = mem_req;
   assign grant_if  = if_req & ~mem_req;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes IF/MEM 32-bit accesses into byte transfers on a single byte-wide RAM.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [3:0]        mem_sel_i,
   input  logic [31:0]       mem_data_i,
   output logic [31:0]       mem_data_o,
   output logic              mem_done_o,
   output logic              stall_req_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);
   state_t state, nstate;
   logic arb_mem, arb_if, accept, gnt_mem, we, we_in, cap_en, unused_hi;
   logic [3:0] sel_in;
   logic [1:0] lane, last, cap_lane;
   logic [31:0] base, wdata, asm_w, if_hold, mem_hold, addr_sum;
   mem_arb u_arb (.if_req(if_req_i), .mem_req(mem_ce_i), .grant_mem(arb_mem), .grant_if(arb_if));
   assign accept = (state == IDLE) & (arb_mem | arb_if);
   assign sel_in = arb_mem ? mem_sel_i : 4'hF;
   assign we_in  = arb_mem & mem_we_i;
   // An empty mask still spends one cycle in RD_WAIT so done lands in cycle 2 with no RAM cycle.
   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (arb_mem | arb_if) nstate = (sel_in == 4'h0) ? RD_WAIT : we_in ? WR : RD;
         RD:      if (lane == last) nstate = RD_WAIT;
         RD_WAIT: nstate = DONE;
         WR:      if (lane == last) nstate = DONE;
         default: nstate = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt_mem  <= 1'b0;
         we       <= 1'b0;
         base     <= ZERO_WORD;
         wdata    <= ZERO_WORD;
         asm_w    <= ZERO_WORD;
         if_hold  <= ZERO_WORD;
         mem_hold <= ZERO_WORD;
         lane     <= 2'd0;
         last     <= 2'd0;
         cap_lane <= 2'd0;
         cap_en   <= 1'b0;
      end else begin
         state    <= nstate;
         cap_en   <= state == RD;
         cap_lane <= lane;
         if (cap_en) asm_w[{cap_lane, 3'b000} +: LANE_W] <= ram_din_i;
         if (accept) begin
            gnt_mem <= arb_mem;
            we      <= we_in;
            base    <= (arb_mem ? mem_addr_i : if_addr_i) & ~32'h3;
            wdata   <= mem_data_i;
            lane    <= lo_lane(sel_in);
            last    <= hi_lane(sel_in);
            asm_w   <= ZERO_WORD;
         end else if (state == RD || state == WR) lane <= lane + 2'd1;
         if (if_done_o) if_hold <= asm_w;
         if (mem_done_o && !we) mem_hold <= asm_w;
      end
   end
   assign addr_sum    = base + {30'b0, lane};
   assign unused_hi   = ^addr_sum[31:ADDR_W];
   assign ram_a_o     = (state == RD || state == WR) ? addr_sum[ADDR_W-1:0] : '0;
   assign ram_wr_o    = state == WR;
   assign ram_dout_o  = ram_wr_o ? wdata[{lane, 3'b000} +: LANE_W] : 8'h0;
   assign if_done_o   = (state == DONE) & ~gnt_mem;
   assign mem_done_o  = (state == DONE) & gnt_mem;
   assign if_data_o   = if_done_o ? asm_w : if_hold;
   assign mem_data_o  = (mem_done_o & ~we) ? asm_w : mem_hold;
   assign stall_req_o = (if_req_i & ~if_done_o) | (mem_ce_i & ~mem_done_o);
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector table plus hand sequences for contention and reset.
module tb_mem_ctrl;
   logic clk = 0, rst = 1;
   logic if_req = 0, mem_ce = 0, mem_we = 0;
   logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
   logic [3:0] mem_sel = 0;
   logic [31:0] if_rdata, mem_rdata;
   logic if_done, mem_done, stall, ram_wr;
   logic [16:0] ram_a;
   logic [7:0] ram_dout, ram_din = 0;
   logic [7:0] ram [0:131071];
   int checks = 0, fails = 0;
   logic [16:0] aq[$];
   logic [7:0] wq[$];
   always #5 clk = ~clk;
   mem_ctrl dut (
      .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_rdata),
      .if_done_o(if_done), .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
      .mem_sel_i(mem_sel), .mem_data_i(mem_wdata), .mem_data_o(mem_rdata), .mem_done_o(mem_done),
      .stall_req_o(stall), .ram_a_o(ram_a), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout), .ram_din_i(ram_din)
   );
   always @(posedge clk) begin
      if (ram_wr) ram[ram_a] <= ram_dout;
      ram_din <= ram[ram_a];
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic xact(input logic is_mem, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, output int cyc, output logic [31:0] data, output int stall_bad);
      repeat (2) @(negedge clk);
      if (is_mem) begin
         mem_ce = 1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wd;
      end else begin
         if_req = 1; if_addr = addr;
      end
      aq.delete(); wq.delete(); cyc = -1; data = 0; stall_bad = 0;
      for (int n = 1; n <= 20 && cyc < 0; n++) begin
         @(posedge clk); #1;
         if (ram_a != 0) aq.push_back(ram_a);
         if (ram_wr) wq.push_back(ram_dout);
         if (is_mem ? mem_done : if_done) begin
            cyc = n; data = is_mem ? mem_rdata : if_rdata;
         end
         if (stall !== (cyc < 0)) stall_bad++;
      end
      mem_ce = 0; if_req = 0;
   endtask
   typedef struct packed {
      logic is_mem; logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wd;
      logic [31:0] exp; logic [4:0] cyc; logic [2:0] nacc; logic [2:0] nwr;
   } vec_t;
   vec_t v [13];
   initial begin
      int cyc, sb, mc, ic;
      logic [31:0] d;
      v[0]  = '{1'b0, 1'b0, 32'h104,  4'hF, 32'h0,        32'h0000_0513, 5'd6, 3'd4, 3'd0};
      v[1]  = '{1'b0, 1'b0, 32'h107,  4'hF, 32'h0,        32'h0000_0513, 5'd6, 3'd4, 3'd0};
      v[2]  = '{1'b1, 1'b0, 32'h10,   4'hC, 32'h0,        32'h1234_0000, 5'd4, 3'd2, 3'd0};
      v[3]  = '{1'b1, 1'b0, 32'h11,   4'h2, 32'h0,        32'h0000_BB00, 5'd3, 3'd1, 3'd0};
      v[4]  = '{1'b1, 1'b0, 32'h10,   4'hF, 32'h0,        32'h1234_BBAA, 5'd6, 3'd4, 3'd0};
      v[5]  = '{1'b1, 1'b1, 32'h2002, 4'h4, 32'h00AB_0000, 32'h1234_BBAA, 5'd2, 3'd1, 3'd1};
      v[6]  = '{1'b1, 1'b0, 32'h2000, 4'hF, 32'h0,        32'h44AB_2211, 5'd6, 3'd4, 3'd0};
      v[7]  = '{1'b1, 1'b1, 32'h2004, 4'hF, 32'hDEAD_BEEF, 32'h44AB_2211, 5'd5, 3'd4, 3'd4};
      v[8]  = '{1'b1, 1'b0, 32'h2004, 4'hF, 32'h0,        32'hDEAD_BEEF, 5'd6, 3'd4, 3'd0};
      v[9]  = '{1'b1, 1'b1, 32'h2006, 4'h3, 32'h0000_CAFE, 32'hDEAD_BEEF, 5'd3, 3'd2, 3'd2};
      v[10] = '{1'b1, 1'b0, 32'h2004, 4'hF, 32'h0,        32'hDEAD_CAFE, 5'd6, 3'd4, 3'd0};
      v[11] = '{1'b1, 1'b0, 32'h10,   4'h0, 32'h0,        32'h0000_0000, 5'd2, 3'd0, 3'd0};
      v[12] = '{1'b0, 1'b0, 32'h2004, 4'hF, 32'h0,        32'hDEAD_CAFE, 5'd6, 3'd4, 3'd0};
      ram[17'h104] = 8'h13; ram[17'h105] = 8'h05; ram[17'h106] = 8'h00; ram[17'h107] = 8'h00;
      ram[17'h10] = 8'hAA; ram[17'h11] = 8'hBB; ram[17'h12] = 8'h34; ram[17'h13] = 8'h12;
      ram[17'h2000] = 8'h11; ram[17'h2001] = 8'h22; ram[17'h2002] = 8'h33; ram[17'h2003] = 8'h44;
      for (int i = 0; i < 8; i++) ram[17'h3000 + 17'(i)] = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      chk("reset ram_wr", {31'b0, ram_wr}, 0);
      chk("reset ram_a", {15'b0, ram_a}, 0);
      chk("reset dones", {30'b0, if_done, mem_done}, 0);
      chk("reset if_data", if_rdata, 0);
      chk("reset mem_data", mem_rdata, 0);
      chk("reset stall", {31'b0, stall}, 0);
      for (int i = 0; i < 13; i++) begin
         xact(v[i].is_mem, v[i].we, v[i].addr, v[i].sel, v[i].wd, cyc, d, sb);
         chk($sformatf("vec%0d done cycle", i), cyc, 32'(v[i].cyc));
         chk($sformatf("vec%0d data", i), d, v[i].exp);
         chk($sformatf("vec%0d ram cycles", i), aq.size(), 32'(v[i].nacc));
         chk($sformatf("vec%0d writes", i), wq.size(), 32'(v[i].nwr));
         chk($sformatf("vec%0d stall", i), sb, 0);
      end
      xact(1'b0, 1'b0, 32'h104, 4'hF, 32'h0, cyc, d, sb);
      for (int i = 0; i < 4; i++) chk($sformatf("fetch addr%0d", i), {15'b0, aq[i]}, 32'h104 + i);
      xact(1'b1, 1'b1, 32'h3004, 4'h4, 32'h00AB_0000, cyc, d, sb);
      chk("byte store addr", {15'b0, aq[0]}, 32'h3006);
      chk("byte store dout", {24'b0, wq[0]}, 32'hAB);
      chk("byte store neighbour", {ram[17'h3005], ram[17'h3006], ram[17'h3007]}, 32'hFFABFF);
      repeat (2) @(negedge clk);
      mem_ce = 1; mem_we = 0; mem_addr = 32'h10; mem_sel = 4'hC; if_req = 1; if_addr = 32'h104;
      mc = -1; ic = -1; sb = 0;
      for (int n = 1; n <= 30 && ic < 0; n++) begin
         @(posedge clk); #1;
         if (stall !== !if_done) sb++;
         if (mem_done) begin
            mc = n; mem_ce = 0;
            chk("contend mem data", mem_rdata, 32'h1234_0000);
         end
         if (if_done) begin
            ic = n; if_req = 0;
            chk("contend if data", if_rdata, 32'h0000_0513);
         end
      end
      if_req = 0; mem_ce = 0;
      chk("contend mem cycle", mc, 4);
      chk("contend if cycle", ic, 11);
      chk("contend stall", sb, 0);
      repeat (2) @(negedge clk);
      mem_ce = 1; mem_we = 1; mem_addr = 32'h3000; mem_sel = 4'hF; mem_wdata = 32'h4433_2211;
      @(posedge clk);
      @(posedge clk); #1;
      chk("pre-reset ram_wr", {31'b0, ram_wr}, 1);
      rst = 1; #1;
      chk("mid reset ram_wr", {31'b0, ram_wr}, 0);
      chk("mid reset ram_a", {15'b0, ram_a}, 0);
      chk("mid reset stall", {31'b0, stall}, 1);
      chk("mid reset outputs", {if_rdata | mem_rdata}, 0);
      chk("mid reset dones", {30'b0, if_done, mem_done}, 0);
      @(negedge clk) mem_ce = 0;
      @(posedge clk);
      @(negedge clk) rst = 0;
      chk("partial store bytes", {ram[17'h3003], ram[17'h3002], ram[17'h3001], ram[17'h3000]}, 32'hFFFF_FF11);
      xact(1'b1, 1'b0, 32'h3000, 4'hF, 32'h0, cyc, d, sb);
      chk("post reset cycle", cyc, 6);
      chk("post reset data", d, 32'hFFFF_FF11);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
